// File: rtl/vnlp_mem_pkg.sv
// Shared definitions for the 512x10 dual-read-port data memory and its clients.
// Holds geometry constants, the reader state encoding and a length clamp helper.
package vnlp_mem_pkg;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 10;
    localparam int MEM_DEPTH = 512;
    localparam int LEN_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } rd_state_t;

    function automatic logic [LEN_W-1:0] clampLen(
        input logic [LEN_W-1:0] len
    );
        if (len > LEN_W'(MEM_DEPTH)) begin
            return LEN_W'(MEM_DEPTH);
        end
        return len;
    endfunction

endpackage

// File: rtl/mem_stream_reader.sv
// Streams a command's worth of words out of the dual-read-port memory,
// two consecutive words per beat, behind a registered valid/ready output.
module mem_stream_reader
    import vnlp_mem_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                CmdValid,
    output logic                CmdReady,
    input  logic [ADDR_W-1:0]   CmdStart,
    input  logic [LEN_W-1:0]    CmdLen,
    input  logic                Abort,
    output logic [ADDR_W-1:0]   ReadAdd1,
    output logic [ADDR_W-1:0]   ReadAdd2,
    input  logic [DATA_W-1:0]   ReadData1,
    input  logic [DATA_W-1:0]   ReadData2,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [2*DATA_W-1:0] OutData,
    output logic [1:0]          OutCount,
    output logic                OutLast,
    output logic                Busy,
    output logic                Done
);

    rd_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  rem;
    logic              beat;
    logic              load;
    logic              twoLeft;
    logic              lastLoad;

    assign beat     = OutValid && OutReady;
    assign load     = !OutValid || OutReady;
    assign twoLeft  = rem >= LEN_W'(2);
    assign lastLoad = rem <= LEN_W'(2);

    assign ReadAdd1 = ptr;
    assign ReadAdd2 = ptr + ADDR_W'(1);

    // Gated by reset so no command can be taken while the block is held.
    assign CmdReady = (state == IDLE) && Rst_n;
    assign Busy     = (state != IDLE);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            rem      <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
            OutCount <= 2'd0;
            OutLast  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CmdValid) begin
                        ptr <= CmdStart;
                        rem <= clampLen(CmdLen);
                        if (CmdLen == '0) begin
                            Done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (Abort) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end else if (load) begin
                        OutValid <= 1'b1;
                        OutData  <= {ReadData2, ReadData1};
                        OutCount <= twoLeft ? 2'd2 : 2'd1;
                        OutLast  <= lastLoad;
                        ptr      <= ptr + ADDR_W'(2);
                        rem      <= rem - (twoLeft ? LEN_W'(2) : LEN_W'(1));
                        if (lastLoad) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (Abort) begin
                        OutValid <= 1'b0;
                        state    <= IDLE;
                    end else if (beat) begin
                        OutValid <= 1'b0;
                        Done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed plus randomized bench for mem_stream_reader against a
// word-list reference model of the command stream.
module tb_mem_stream_reader;
    import vnlp_mem_pkg::*;

    logic                Clk = 1'b0;
    logic                Rst_n = 1'b0;
    logic                CmdValid = 1'b0;
    logic                CmdReady;
    logic [ADDR_W-1:0]   CmdStart = '0;
    logic [LEN_W-1:0]    CmdLen = '0;
    logic                Abort = 1'b0;
    logic [ADDR_W-1:0]   ReadAdd1;
    logic [ADDR_W-1:0]   ReadAdd2;
    logic [DATA_W-1:0]   ReadData1;
    logic [DATA_W-1:0]   ReadData2;
    logic                OutValid;
    logic                OutReady = 1'b0;
    logic [2*DATA_W-1:0] OutData;
    logic [1:0]          OutCount;
    logic                OutLast;
    logic                Busy;
    logic                Done;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    assign ReadData1 = mem[ReadAdd1];
    assign ReadData2 = mem[ReadAdd2];

    mem_stream_reader dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdStart (CmdStart),
        .CmdLen   (CmdLen),
        .Abort    (Abort),
        .ReadAdd1 (ReadAdd1),
        .ReadAdd2 (ReadAdd2),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutCount (OutCount),
        .OutLast  (OutLast),
        .Busy     (Busy),
        .Done     (Done)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fillMem(input bit rnd);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = rnd ? DATA_W'($urandom) : DATA_W'(i);
        end
    endtask

    // Beat k of a command covers words start+2k and start+2k+1 (mod depth).
    task automatic checkBeat(input int start, input int n, input int k);
        int cnt;
        cnt = (n - 2 * k >= 2) ? 2 : 1;
        check("beat_w1", {22'd0, OutData[DATA_W-1:0]},
              {22'd0, mem[(start + 2 * k) % MEM_DEPTH]});
        if (cnt == 2) begin
            check("beat_w2", {22'd0, OutData[2*DATA_W-1:DATA_W]},
                  {22'd0, mem[(start + 2 * k + 1) % MEM_DEPTH]});
        end
        check("beat_cnt", {30'd0, OutCount}, cnt);
        check("beat_last", {31'd0, OutLast}, (k == (n + 1) / 2 - 1) ? 1 : 0);
    endtask

    task automatic runCmd(input int start, input int len, input int readyPct,
                          input int abortAt, input int stallFirst);
        int n;
        int nb;
        int k;
        int stalls;
        bit finished;
        bit holdPend;
        logic [2*DATA_W-1:0] holdData;
        n = (len > MEM_DEPTH) ? MEM_DEPTH : len;
        nb = (n + 1) / 2;
        check("cmd_ready", {31'd0, CmdReady}, 1);
        CmdValid = 1'b1;
        CmdStart = ADDR_W'(start);
        CmdLen   = LEN_W'(len);
        @(negedge Clk);
        CmdValid = 1'b0;
        if (n == 0) begin
            check("len0_done", {31'd0, Done}, 1);
            check("len0_busy", {31'd0, Busy}, 0);
            check("len0_valid", {31'd0, OutValid}, 0);
            @(negedge Clk);
            check("len0_done_pulse", {31'd0, Done}, 0);
            check("len0_valid2", {31'd0, OutValid}, 0);
            return;
        end
        check("run_busy", {31'd0, Busy}, 1);
        check("run_valid", {31'd0, OutValid}, 0);
        check("run_addr1", {23'd0, ReadAdd1}, start % MEM_DEPTH);
        check("run_addr2", {23'd0, ReadAdd2}, (start + 1) % MEM_DEPTH);
        k = 0;
        stalls = 0;
        finished = 0;
        holdPend = 0;
        holdData = '0;
        for (int cyc = 0; cyc < 20 * nb + 50 && !finished; cyc++) begin
            @(negedge Clk);
            if (k == nb) begin
                check("done", {31'd0, Done}, 1);
                check("ready_after", {31'd0, CmdReady}, 1);
                check("valid_after", {31'd0, OutValid}, 0);
                finished = 1;
            end else begin
                check("no_done", {31'd0, Done}, 0);
                if (holdPend) begin
                    check("hold_valid", {31'd0, OutValid}, 1);
                    check("hold_data", {12'd0, OutData}, {12'd0, holdData});
                end
                OutReady = ($urandom_range(99) < readyPct);
                if (k == 0 && OutValid && stalls < stallFirst) begin
                    OutReady = 1'b0;
                    stalls++;
                end
                if (abortAt == k && OutValid) begin
                    Abort = 1'b1;
                    if (OutReady) checkBeat(start, n, k);
                    @(negedge Clk);
                    Abort = 1'b0;
                    OutReady = 1'b0;
                    check("abort_valid", {31'd0, OutValid}, 0);
                    check("abort_busy", {31'd0, Busy}, 0);
                    check("abort_done", {31'd0, Done}, 0);
                    @(negedge Clk);
                    check("abort_nodone", {31'd0, Done}, 0);
                    check("abort_ready", {31'd0, CmdReady}, 1);
                    finished = 1;
                end else if (OutValid && OutReady) begin
                    checkBeat(start, n, k);
                    k++;
                    holdPend = 0;
                end else begin
                    holdPend = OutValid;
                    holdData = OutData;
                end
            end
        end
        if (!finished) check("timeout", 0, 1);
        OutReady = 1'b0;
    endtask

    initial begin
        fillMem(0);
        #1;
        check("rst_ready", {31'd0, CmdReady}, 0);
        check("rst_valid", {31'd0, OutValid}, 0);
        check("rst_busy", {31'd0, Busy}, 0);
        check("rst_done", {31'd0, Done}, 0);
        check("rst_cnt", {30'd0, OutCount}, 0);
        check("rst_data", {12'd0, OutData}, 0);
        check("rst_addr1", {23'd0, ReadAdd1}, 0);
        check("rst_addr2", {23'd0, ReadAdd2}, 1);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, CmdReady}, 1);

        runCmd(10, 5, 100, -1, 0);
        runCmd(510, 4, 100, -1, 0);
        runCmd(0, 8, 100, -1, 3);
        runCmd(7, 0, 100, -1, 0);
        runCmd(0, 600, 100, -1, 0);
        runCmd(20, 10, 100, 1, 0);
        runCmd(3, 1, 100, -1, 0);

        CmdValid = 1'b1;
        CmdStart = ADDR_W'(0);
        CmdLen   = LEN_W'(100);
        @(negedge Clk);
        CmdValid = 1'b0;
        OutReady = 1'b1;
        repeat (4) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, OutValid}, 0);
        check("mid_rst_busy", {31'd0, Busy}, 0);
        check("mid_rst_ready", {31'd0, CmdReady}, 0);
        check("mid_rst_data", {12'd0, OutData}, 0);
        check("mid_rst_cnt", {30'd0, OutCount}, 0);
        check("mid_rst_last", {31'd0, OutLast}, 0);
        check("mid_rst_done", {31'd0, Done}, 0);
        check("mid_rst_addr1", {23'd0, ReadAdd1}, 0);
        check("mid_rst_addr2", {23'd0, ReadAdd2}, 1);
        OutReady = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, CmdReady}, 1);
        runCmd(100, 7, 70, -1, 0);

        fillMem(1);
        for (int t = 0; t < 25; t++) begin
            int s;
            int l;
            int p;
            int a;
            s = $urandom_range(MEM_DEPTH - 1);
            l = ($urandom_range(9) == 0) ? $urandom_range(1023)
                                         : $urandom_range(40);
            p = $urandom_range(100, 30);
            a = ($urandom_range(4) == 0) ? $urandom_range(10) : -1;
            runCmd(s, l, p, a, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
